// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the instruction-memory boot loader.
//   loader_state_t  - loader FSM states
//   HDR_BYTES       - bytes in the word-count header (little-endian)
//   WORD_BITS       - width of one packed program word
//   BYTES_PER_WORD  - stream bytes consumed per program word
package loader_pkg;

    typedef enum logic [2:0] {
        HDR0  = 3'd0,
        HDR1  = 3'd1,
        DATA  = 3'd2,
        WLAST = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } loader_state_t;

    localparam int HDR_BYTES      = 2;
    localparam int WORD_BITS      = 32;
    localparam int BYTES_PER_WORD = WORD_BITS / 8;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: collects bytes little-endian into one program word.
//   clock     in   single clock
//   reset     in   synchronous, active-high
//   byteIn    in   incoming byte
//   byteEn    in   byteIn is consumed this cycle
//   clear     in   drop any partial word
//   wordOut   out  completed word (valid only while wordValid is high)
//   wordValid out  high in the cycle the last byte of a word is consumed
module byte_packer
    import loader_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           byteIn,
    input  logic                 byteEn,
    input  logic                 clear,
    output logic [WORD_BITS-1:0] wordOut,
    output logic                 wordValid
);

    logic [1:0]           byteCnt;
    // Only the first three bytes need storage; the fourth is taken straight
    // from byteIn so the word is available on the same edge it completes.
    logic [WORD_BITS-9:0] shreg;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            byteCnt <= 2'd0;
            shreg   <= '0;
        end else if (byteEn) begin
            shreg   <= {byteIn, shreg[WORD_BITS-9:8]};
            byteCnt <= byteCnt + 2'd1;
        end
    end

    assign wordValid = byteEn && (byteCnt == 2'(BYTES_PER_WORD - 1));
    assign wordOut   = {byteIn, shreg};

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot loader feeding the processor's instruction-memory write port.
//   clock/reset          single clock, synchronous active-high reset
//   rxData/rxValid/rxReady  byte stream in: count[7:0], count[15:8], count*4 data bytes
//   reload               restart a load from DONE or ERROR
//   insMemEn/Addr/Data   one-cycle word writes at word indices 0..count-1
//   cpuReset             holds the processor in reset until the load is DONE
//   loadDone/loadError   status; wordCount is the latched header count
module imem_loader
    import loader_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 512,
    parameter int TIMEOUT = 1000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       rxData,
    input  logic             rxValid,
    output logic             rxReady,
    input  logic             reload,
    output logic             insMemEn,
    output logic [WIDTH-1:0] insMemAddr,
    output logic [WIDTH-1:0] insMemData,
    output logic             cpuReset,
    output logic             loadDone,
    output logic             loadError,
    output logic [15:0]      wordCount
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = $clog2(TIMEOUT);

    loader_state_t        state;
    logic [7:0]           cntLo;
    logic [AW-1:0]        wordIdx;
    logic [IW-1:0]        idle;
    logic                 accept;
    logic [15:0]          hdrCount;
    logic                 timeout;
    logic                 lastWord;
    logic [WORD_BITS-1:0] packWord;
    logic                 packValid;

    assign rxReady  = !reset && (state == HDR0 || state == HDR1 || state == DATA);
    assign accept   = rxValid && rxReady;
    assign hdrCount = {rxData, cntLo};
    assign timeout  = (idle == IW'(TIMEOUT - 1));
    assign lastWord = (16'(wordIdx) == wordCount - 16'd1);

    // Outside DATA the packer is held clear, which also discards a partial
    // word when a timeout aborts the load.
    byte_packer u_packer (
        .clock     (clock),
        .reset     (reset),
        .byteIn    (rxData),
        .byteEn    (accept && state == DATA),
        .clear     (state != DATA),
        .wordOut   (packWord),
        .wordValid (packValid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= HDR0;
            cntLo      <= 8'd0;
            wordIdx    <= '0;
            idle       <= '0;
            insMemEn   <= 1'b0;
            insMemAddr <= '0;
            insMemData <= '0;
            cpuReset   <= 1'b1;
            loadDone   <= 1'b0;
            loadError  <= 1'b0;
            wordCount  <= 16'd0;
        end else begin
            insMemEn <= 1'b0;
            case (state)
                HDR0: begin
                    if (accept) begin
                        cntLo <= rxData;
                        idle  <= '0;
                        state <= HDR1;
                    end
                end
                HDR1: begin
                    if (accept) begin
                        wordCount <= hdrCount;
                        wordIdx   <= '0;
                        idle      <= '0;
                        if (hdrCount == 16'd0) begin
                            state    <= DONE;
                            cpuReset <= 1'b0;
                            loadDone <= 1'b1;
                        end else if (32'(hdrCount) > DEPTH) begin
                            state     <= ERROR;
                            loadError <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end else if (timeout) begin
                        state     <= ERROR;
                        loadError <= 1'b1;
                    end else begin
                        idle <= idle + IW'(1);
                    end
                end
                DATA: begin
                    if (accept) begin
                        idle <= '0;
                        if (packValid) begin
                            insMemEn   <= 1'b1;
                            insMemAddr <= WIDTH'(wordIdx);
                            insMemData <= WIDTH'(packWord);
                            wordIdx    <= wordIdx + AW'(1);
                            if (lastWord) state <= WLAST;
                        end
                    end else if (timeout) begin
                        state     <= ERROR;
                        loadError <= 1'b1;
                    end else begin
                        idle <= idle + IW'(1);
                    end
                end
                // The last write is still on the port here; the processor
                // leaves reset on the following edge.
                WLAST: begin
                    state    <= DONE;
                    cpuReset <= 1'b0;
                    loadDone <= 1'b1;
                end
                DONE, ERROR: begin
                    if (reload) begin
                        state     <= HDR0;
                        cpuReset  <= 1'b1;
                        loadDone  <= 1'b0;
                        loadError <= 1'b0;
                        wordCount <= 16'd0;
                    end
                end
                default: state <= HDR0;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed stimulus against a byte-stream level model of the loader.
module tb_imem_loader;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 512;
    localparam int TIMEOUT = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [7:0]       rxData = 8'd0;
    logic             rxValid = 1'b0;
    logic             rxReady;
    logic             reload = 1'b0;
    logic             insMemEn;
    logic [WIDTH-1:0] insMemAddr;
    logic [WIDTH-1:0] insMemData;
    logic             cpuReset;
    logic             loadDone;
    logic             loadError;
    logic [15:0]      wordCount;

    imem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .rxData(rxData), .rxValid(rxValid), .rxReady(rxReady),
        .reload(reload), .insMemEn(insMemEn), .insMemAddr(insMemAddr), .insMemData(insMemData),
        .cpuReset(cpuReset), .loadDone(loadDone), .loadError(loadError), .wordCount(wordCount)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model: byte-count view of one load ----------------
    int          m_nb;          // bytes accepted since the load started
    int          m_cnt;
    int          m_last;        // cycle index of the last accepted byte
    int          cyc = 0;
    bit          m_done, m_err, m_wlast, armed = 0;
    bit          m_en;
    logic [31:0] m_addr, m_data;
    logic [15:0] m_wc;
    logic [7:0]  m_lo;
    logic [7:0]  m_b [4];

    logic [63:0] wlog [$];
    logic [31:0] dmem [DEPTH];

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
            begin
                bit acc;
                int k;
                acc = rxValid && !reset && !m_done && !m_err && !m_wlast;
                if (reset) begin
                    m_nb = 0; m_done = 0; m_err = 0; m_wlast = 0; m_wc = 0;
                    m_en = 0; m_addr = 0; m_data = 0; armed = 1;
                end else begin
                    m_en = 0;
                    if (m_wlast) begin
                        m_wlast = 0; m_done = 1;
                    end else if (m_done || m_err) begin
                        if (reload) begin m_done = 0; m_err = 0; m_nb = 0; m_wc = 0; end
                    end else if (acc) begin
                        m_last = cyc;
                        if (m_nb == 0) m_lo = rxData;
                        else if (m_nb == 1) begin
                            m_cnt = {rxData, m_lo};
                            m_wc = m_cnt[15:0];
                            if (m_cnt == 0) m_done = 1;
                            else if (m_cnt > DEPTH) m_err = 1;
                        end else begin
                            k = m_nb - 2;
                            m_b[k % 4] = rxData;
                            if (k % 4 == 3) begin
                                m_en = 1; m_addr = k / 4;
                                m_data = {m_b[3], m_b[2], m_b[1], m_b[0]};
                                if (k / 4 == m_cnt - 1) m_wlast = 1;
                            end
                        end
                        m_nb++;
                    end else if (m_nb > 0 && cyc - m_last == TIMEOUT) begin
                        m_err = 1;
                    end
                end
            end
            #1;
            if (armed) begin
                chk("rxReady", rxReady, !reset && !m_done && !m_err && !m_wlast);
                chk("insMemEn", insMemEn, m_en);
                if (m_en) begin
                    chk("insMemAddr", insMemAddr, m_addr);
                    chk("insMemData", insMemData, m_data);
                end
                chk("cpuReset", cpuReset, !m_done);
                chk("loadDone", loadDone, m_done);
                chk("loadError", loadError, m_err);
                chk("wordCount", wordCount, m_wc);
            end
            if (insMemEn === 1'b1) begin
                wlog.push_back({insMemAddr, insMemData});
                dmem[insMemAddr[8:0]] = insMemData;
            end
        end
    end

    // ---------------- driver ----------------
    // One call = one clock edge; returns just after that edge.
    task automatic step(input logic v, input logic [7:0] b, input logic rl, input logic rs);
        @(negedge clock);
        rxValid = v; rxData = b; reload = rl; reset = rs;
        @(posedge clock);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        step(1, b, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0);
    endtask

    initial begin
        logic [7:0] s1 [10];
        logic [7:0] s5 [14];
        int         g5 [14];
        s1 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        s5 = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
               8'h99, 8'hAA, 8'hBB, 8'hCC};
        g5 = '{0, 3, 1, 5, 0, 2, 4, 0, 1, 5, 2, 0, 3, 1};

        // reset
        step(0, 0, 0, 1); step(0, 0, 0, 1);
        chk("rst_rxReady", rxReady, 0);
        chk("rst_cpuReset", cpuReset, 1);
        step(0, 0, 0, 0);
        chk("rst_insMemAddr", insMemAddr, 0);
        chk("rst_insMemData", insMemData, 0);

        // 1: two words back to back
        wlog.delete();
        for (int i = 0; i < 10; i++) send(s1[i]);
        chk("t1_en_last", insMemEn, 1);
        chk("t1_cpuReset_wlast", cpuReset, 1);
        idle(1);
        chk("t1_en_off", insMemEn, 0);
        chk("t1_cpuReset_fall", cpuReset, 0);
        idle(1);
        chk("t1_nwrites", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("t1_w0", wlog[0], {32'd0, 32'h00000013});
            chk("t1_w1", wlog[1], {32'd1, 32'h00100093});
        end
        chk("t1_loadDone", loadDone, 1);
        chk("t1_wordCount", wordCount, 2);

        // 2: empty program
        step(0, 0, 1, 0);
        wlog.delete();
        send(8'h00); send(8'h00);
        idle(1);
        chk("t2_cpuReset", cpuReset, 0);
        chk("t2_loadDone", loadDone, 1);
        chk("t2_nwrites", wlog.size(), 0);

        // 3: count 513 rejected, then reload
        step(0, 0, 1, 0);
        send(8'h01); send(8'h02);
        chk("t3_loadError", loadError, 1);
        chk("t3_rxReady_err", rxReady, 0);
        step(0, 0, 1, 0);
        chk("t3_rxReady_reload", rxReady, 1);
        chk("t3_loadError_clr", loadError, 0);

        // 4: timeout mid-word
        wlog.delete();
        send(8'h01); send(8'h00);
        send(8'hA1); send(8'hA2); send(8'hA3);
        idle(TIMEOUT - 1);
        chk("t4_no_err_yet", loadError, 0);
        idle(1);
        chk("t4_err", loadError, 1);
        idle(3);
        chk("t4_nwrites", wlog.size(), 0);

        // 5a: three words with gaps
        step(0, 0, 1, 0);
        wlog.delete();
        for (int i = 0; i < 14; i++) begin idle(g5[i]); send(s5[i]); end
        idle(2);
        chk("t5_nwrites", wlog.size(), 3);
        if (wlog.size() == 3) begin
            chk("t5_w0", wlog[0], {32'd0, 32'h44332211});
            chk("t5_w1", wlog[1], {32'd1, 32'h88776655});
            chk("t5_w2", wlog[2], {32'd2, 32'hCCBBAA99});
        end
        // 5b: reset after word 1
        step(0, 0, 1, 0);
        wlog.delete();
        for (int i = 0; i < 10; i++) begin idle(g5[i]); send(s5[i]); end
        step(0, 0, 0, 1); step(0, 0, 0, 1);
        idle(5);
        chk("t5_reset_nwrites", wlog.size(), 2);
        chk("t5_reset_cpuReset", cpuReset, 1);
        chk("t5_reset_rxReady", rxReady, 1);

        // 6: bytes ignored in DONE, reload overwrites word 0
        send(8'h02); send(8'h00);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h05); send(8'h06); send(8'h07); send(8'h08);
        idle(1);
        wlog.delete();
        send(8'h55); send(8'h66); send(8'h77);
        chk("t6_done_rxReady", rxReady, 0);
        chk("t6_done_nwrites", wlog.size(), 0);
        step(0, 0, 1, 0);
        send(8'h01); send(8'h00);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        idle(2);
        chk("t6_mem0", dmem[0], 32'hEFBEADDE);
        chk("t6_mem1", dmem[1], 32'h08070605);
        chk("t6_loadDone", loadDone, 1);
        chk("t6_wordCount", wordCount, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
